mux_arb_nto1: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes. It is the sequential successor of the pipeline's combinational select muxes. Each cycle it picks one requesting input channel, either by explicit select (directed mode) or by round-robin arbitration, and captures that word into a single output register. It sits wherever several producers share one pipeline consumer, for example writeback sources or shared-bus masters.

---
 rtl/mux_arb_nto1_if.sv | 27 ++
 rtl/mux_arb_nto1.sv | 98 +++++++++
 2 files changed

// File: rtl/mux_arb_nto1_if.sv
// mux_arb_nto1 handshake bundle: producer-side channels plus the
// single registered consumer port.
interface mux_arb_nto1_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      mode_i;
  logic [SEL_W-1:0]          select_i;
  logic [CHANNELS*WIDTH-1:0] data_i;
  logic [CHANNELS-1:0]       valid_i;
  logic [CHANNELS-1:0]       ready_o;
  logic [WIDTH-1:0]          data_o;
  logic [SEL_W-1:0]          chan_o;
  logic                      valid_o;
  logic                      ready_i;

  modport master (
    output mode_i, select_i, data_i, valid_i, ready_i,
    input  ready_o, data_o, chan_o, valid_o
  );

  modport slave (
    input  mode_i, select_i, data_i, valid_i, ready_i,
    output ready_o, data_o, chan_o, valid_o
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 registered mux with directed or round-robin selection
// and valid/ready handshakes on every channel and the output.
module mux_arb_nto1 #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  mux_arb_nto1_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    dir_gnt;
  logic [SEL_W-1:0]    rr_gnt;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W-1:0]    chan_q;
  logic [CHANNELS-1:0] hi_req;
  logic [CHANNELS-1:0] rr_req;
  logic [CHANNELS-1:0] ready;
  logic [WIDTH-1:0]    sel_data;
  logic [WIDTH-1:0]    data_q;
  logic                dir_hit;
  logic                rr_hit;
  logic                gnt_vld;
  logic                accept;
  logic                load;
  logic                valid_q;

  // Directed grant: out-of-range selects match no channel.
  always_comb begin
    dir_gnt = '0;
    dir_hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.select_i == SEL_W'(k) && bus.valid_i[k]) begin
        dir_gnt = SEL_W'(k);
        dir_hit = 1'b1;
      end
    end
  end

  // Round-robin: lowest requester above rr_ptr, else lowest overall.
  always_comb begin
    hi_req = '0;
    rr_gnt = '0;
    rr_hit = |bus.valid_i;
    for (int k = 0; k < CHANNELS; k++) begin
      hi_req[k] = bus.valid_i[k] && (SEL_W'(k) > rr_ptr);
    end
    rr_req = (|hi_req) ? hi_req : bus.valid_i;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rr_req[k]) begin
        rr_gnt = SEL_W'(k);
      end
    end
  end

  // Final grant, accept, per-channel ready and word select.
  always_comb begin
    grant    = bus.mode_i ? rr_gnt : dir_gnt;
    gnt_vld  = bus.mode_i ? rr_hit : dir_hit;
    accept   = !rst_i && (!valid_q || bus.ready_i);
    load     = accept && gnt_vld;
    sel_data = '0;
    ready    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant == SEL_W'(k)) begin
        sel_data = bus.data_i[k*WIDTH +: WIDTH];
        ready[k] = load;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      rr_ptr  <= LAST;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= sel_data;
      chan_q  <= grant;
      if (bus.mode_i) begin
        rr_ptr <= grant;
      end
    end else if (bus.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_o = ready;
  assign bus.data_o  = data_q;
  assign bus.chan_o  = chan_q;
  assign bus.valid_o = valid_q;
endmodule
